tank_sprite_ctl: RTL and testbench



---
 rtl/tank_sprite_ctl.sv | 75 +++++++
 tb/tb_tank_sprite_ctl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/tank_sprite_ctl.sv
// tank_sprite_ctl: overlays two tanks sharing one sprite ROM onto the VGA stream.
module tank_sprite_ctl #(
  parameter int          TANK_W  = 48,
  parameter int          TANK_H  = 64,
  parameter logic [11:0] KEY_RGB = 12'hF0F
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos0,
  input  logic [10:0] ypos0,
  input  logic [10:0] xpos1,
  input  logic [10:0] ypos1,
  input  logic        en0,
  input  logic        en1,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  logic [10:0] x0_q, y0_q, x1_q, y1_q;
  logic        en0_q, en1_q, vb_q;
  logic        hit1_q, hit2_q;
  logic [37:0] p1_q, p2_q;
  logic        hit0, hit1;
  logic [10:0] xs, ys;
  logic [5:0]  dx, dy;

  function automatic logic in_box(input logic en, input logic [10:0] h, v, x, y);
    // widen to 12 bits so x+TANK_W near 2047 does not wrap
    return en && ({1'b0, h} >= {1'b0, x}) && ({1'b0, h} < {1'b0, x} + 12'(TANK_W)) &&
           ({1'b0, v} >= {1'b0, y}) && ({1'b0, v} < {1'b0, y} + 12'(TANK_H));
  endfunction

  always_comb begin
    hit0 = !hblnk_in && !vblnk_in && in_box(en0_q, hcount_in, vcount_in, x0_q, y0_q);
    hit1 = !hblnk_in && !vblnk_in && in_box(en1_q, hcount_in, vcount_in, x1_q, y1_q);
    xs   = hit0 ? x0_q : x1_q;
    ys   = hit0 ? y0_q : y1_q;
    dx   = 6'(hcount_in - xs);
    dy   = 6'(vcount_in - ys);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      {x0_q, y0_q, x1_q, y1_q, en0_q, en1_q, vb_q} <= '0;
      {hit1_q, hit2_q, p1_q, p2_q, rom_addr} <= '0;
      {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} <= '0;
    end else begin
      vb_q <= vblnk_in;
      if (vblnk_in && !vb_q) begin
        {x0_q, y0_q, en0_q} <= {xpos0, ypos0, en0};
        {x1_q, y1_q, en1_q} <= {xpos1, ypos1, en1};
      end
      if (hit0 || hit1) rom_addr <= {dy, dx};
      hit1_q <= hit0 || hit1;
      hit2_q <= hit1_q;
      p1_q   <= {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
      p2_q   <= p1_q;
      {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= p2_q[37:12];
      rgb_out <= (hit2_q && rom_rgb != KEY_RGB) ? rom_rgb : p2_q[11:0];
    end
  end
endmodule

// File: tb/tb_tank_sprite_ctl.sv
// tb_tank_sprite_ctl: directed-vector bench for the two-tank sprite overlay.
module tb_tank_sprite_ctl;
  logic        pclk = 0, rst = 1;
  logic [10:0] hcount_in = 0, vcount_in = 0;
  logic        hsync_in = 0, vsync_in = 0, hblnk_in = 1, vblnk_in = 0;
  logic [11:0] rgb_in = 0;
  logic [10:0] xpos0 = 0, ypos0 = 0, xpos1 = 0, ypos1 = 0;
  logic        en0 = 0, en1 = 0;
  logic [11:0] rom_addr, rom_rgb, rgb_out;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  int n_tests = 0, n_fail = 0;

  always #5 pclk = ~pclk;

  tank_sprite_ctl dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .xpos0(xpos0), .ypos0(ypos0), .xpos1(xpos1), .ypos1(ypos1),
    .en0(en0), .en1(en1),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Synchronous ROM model: word = addr + 0x100, except two transparent entries.
  function automatic logic [11:0] rom_val(input logic [11:0] a);
    return (a == 12'h005 || a == 12'h29E) ? 12'hF0F : a + 12'h100;
  endfunction

  always_ff @(posedge pclk) rom_rgb <= rom_val(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic vedge();
    @(negedge pclk) {hblnk_in, vblnk_in} = 2'b10;
    @(negedge pclk) vblnk_in = 1;
    @(negedge pclk) vblnk_in = 0;
  endtask

  task automatic pix(input string tag, input logic [10:0] h, v, input logic [11:0] rgb,
                     input logic [11:0] exp_addr, exp_rgb);
    @(negedge pclk) begin
      hcount_in = h; vcount_in = v; rgb_in = rgb;
      hsync_in = 1; hblnk_in = 0; vblnk_in = 0;
    end
    @(negedge pclk) chk({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    @(negedge pclk);
    @(negedge pclk) begin
      chk({tag, "_rgb"}, 32'(rgb_out), 32'(exp_rgb));
      chk({tag, "_hcnt"}, 32'(hcount_out), 32'(h));
      chk({tag, "_vcnt"}, 32'(vcount_out), 32'(v));
      chk({tag, "_hsync"}, 32'(hsync_out), 32'd1);
    end
  endtask

  initial begin
    logic [10:0] hist [0:15];
    hcount_in = 11'd5; hsync_in = 1; rgb_in = 12'hABC;
    repeat (2) @(negedge pclk);
    chk("rst_rgb", 32'(rgb_out), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_hcnt", 32'(hcount_out), 0);
    chk("rst_hsync", 32'(hsync_out), 0);
    rst = 0;
    {xpos0, ypos0, en0} = {11'd100, 11'd200, 1'b1};
    pix("pre_latch", 11'd100, 11'd200, 12'h0A0, 12'h000, 12'h0A0);
    vedge();
    pix("tl", 11'd100, 11'd200, 12'h0A0, 12'h000, 12'h100);
    pix("br", 11'd147, 11'd263, 12'h0A0, 12'hFEF, 12'h0EF);
    pix("right_out", 11'd148, 11'd200, 12'h0A1, 12'hFEF, 12'h0A1);
    pix("bot_out", 11'd100, 11'd264, 12'h0A2, 12'hFEF, 12'h0A2);
    pix("key", 11'd105, 11'd200, 12'h0A3, 12'h005, 12'h0A3);
    pix("opaque", 11'd135, 11'd200, 12'h0A4, 12'h023, 12'h123);
    // exact 3-cycle latency on counts and sync with a changing stream
    for (int i = 0; i < 13; i++) begin
      @(negedge pclk);
      if (i >= 3) begin
        chk("lat_hcnt", 32'(hcount_out), 32'(hist[i-3]));
        chk("lat_hsync", 32'(hsync_out), 32'(hist[i-3][0]));
      end
      hist[i] = 11'(i * 7 + 1);
      hcount_in = hist[i]; hsync_in = hist[i][0]; hblnk_in = 1;
    end
    {xpos1, ypos1, en1} = {11'd120, 11'd200, 1'b1};
    vedge();
    pix("ovl_key", 11'd130, 11'd210, 12'h0B0, 12'h29E, 12'h0B0);
    pix("tank1", 11'd160, 11'd210, 12'h0B1, 12'h2A8, 12'h3A8);
    xpos0 = 11'd300;
    pix("shadow_old", 11'd100, 11'd200, 12'h0C0, 12'h000, 12'h100);
    pix("shadow_new_hidden", 11'd300, 11'd200, 12'h0C1, 12'h000, 12'h0C1);
    vedge();
    pix("moved", 11'd301, 11'd201, 12'h0C2, 12'h041, 12'h141);
    pix("old_gone", 11'd100, 11'd200, 12'h0C3, 12'h041, 12'h0C3);
    @(negedge pclk) begin
      rst = 1; hcount_in = 11'd301; vcount_in = 11'd201; hblnk_in = 0; hsync_in = 1;
    end
    @(negedge pclk) begin
      chk("mrst_rgb", 32'(rgb_out), 0);
      chk("mrst_addr", 32'(rom_addr), 0);
      chk("mrst_hcnt", 32'(hcount_out), 0);
      chk("mrst_hsync", 32'(hsync_out), 0);
      rst = 0;
    end
    pix("mrst_hidden", 11'd301, 11'd201, 12'h0D0, 12'h000, 12'h0D0);
    vedge();
    pix("mrst_back", 11'd301, 11'd201, 12'h0D1, 12'h041, 12'h141);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
